// File: rtl/ptw_axim_arbiter_if.sv
// Walker-side and AXI-master-side signals of the PTW read arbiter.
// slave = the arbiter itself; master = the TLBs and AXI master around it.
interface ptw_axim_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic                  I_ADDR_VALID;
    logic [ADDR_WIDTH-1:0] I_ADDR;
    logic                  I_DATA_VALID;
    logic [DATA_WIDTH-1:0] I_DATA;
    logic                  I_ERR;
    logic                  D_ADDR_VALID;
    logic [ADDR_WIDTH-1:0] D_ADDR;
    logic                  D_DATA_VALID;
    logic [DATA_WIDTH-1:0] D_DATA;
    logic                  D_ERR;
    logic                  M_ADDR_READY;
    logic                  M_ADDR_VALID;
    logic [ADDR_WIDTH-1:0] M_ADDR;
    logic                  M_DATA_VALID;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic                  M_ERR;

    modport slave (
        input  I_ADDR_VALID, I_ADDR, D_ADDR_VALID, D_ADDR,
        input  M_ADDR_READY, M_DATA_VALID, M_DATA, M_ERR,
        output I_DATA_VALID, I_DATA, I_ERR, D_DATA_VALID, D_DATA, D_ERR,
        output M_ADDR_VALID, M_ADDR
    );

    modport master (
        output I_ADDR_VALID, I_ADDR, D_ADDR_VALID, D_ADDR,
        output M_ADDR_READY, M_DATA_VALID, M_DATA, M_ERR,
        input  I_DATA_VALID, I_DATA, I_ERR, D_DATA_VALID, D_DATA, D_ERR,
        input  M_ADDR_VALID, M_ADDR
    );
endinterface

// File: rtl/ptw_axim_arbiter.sv
// Shares one AXI read channel between the ITLB and DTLB page-table walkers:
// one buffered request per walker, one transaction outstanding, response routed to its owner.
module ptw_axim_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int RR_ENABLE  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FLUSH,
    ptw_axim_arbiter_if.slave     bus,
    output logic [1:0]            OVERFLOW,
    output logic [0:0]            o_state
);
    // Handshake: walkers and the master exchange single-cycle pulses; an address is
    // only issued while M_ADDR_READY is high, and each issue is answered by exactly one
    // M_DATA_VALID pulse before the next issue.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic       RR_ON   = (RR_ENABLE != 0) ? 1'b1 : 1'b0;

    logic [0:0]            r_state;
    logic                  r_pend_i;
    logic                  r_pend_d;
    logic [ADDR_WIDTH-1:0] r_buf_i;
    logic [ADDR_WIDTH-1:0] r_buf_d;
    logic                  r_owner_d;
    logic                  r_last_d;
    logic                  r_drop;
    logic                  r_m_addr_valid;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic [1:0]            r_overflow;

    logic                  w_issue;
    logic                  w_sel_d;
    logic                  w_resp;
    logic                  w_deliver;
    logic                  w_keep_i;
    logic                  w_keep_d;
    logic [DATA_WIDTH-1:0] w_m_data;

    always_comb begin
        // DTLB wins when it is alone, or in round-robin mode when ITLB was served last.
        w_sel_d   = r_pend_d & (~r_pend_i | (RR_ON & ~r_last_d));
        w_issue   = (r_state == ST_IDLE) & (r_pend_i | r_pend_d) & bus.M_ADDR_READY;
        w_resp    = (r_state == ST_WAIT) & bus.M_DATA_VALID;
        w_deliver = w_resp & ~r_drop & ~FLUSH;
        // Pending entries that survive this cycle (FLUSH clears before capture).
        w_keep_i  = r_pend_i & ~(w_issue & ~w_sel_d) & ~FLUSH;
        w_keep_d  = r_pend_d & ~(w_issue & w_sel_d) & ~FLUSH;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= ST_IDLE;
            r_pend_i       <= 1'b0;
            r_pend_d       <= 1'b0;
            r_buf_i        <= '0;
            r_buf_d        <= '0;
            r_owner_d      <= 1'b0;
            r_last_d       <= 1'b1;
            r_drop         <= 1'b0;
            r_m_addr_valid <= 1'b0;
            r_m_addr       <= '0;
            r_overflow     <= 2'b00;
        end else begin
            r_pend_i       <= w_keep_i | bus.I_ADDR_VALID;
            r_pend_d       <= w_keep_d | bus.D_ADDR_VALID;
            r_m_addr_valid <= w_issue;
            if (bus.I_ADDR_VALID) begin
                r_buf_i <= bus.I_ADDR;
            end
            if (bus.D_ADDR_VALID) begin
                r_buf_d <= bus.D_ADDR;
            end
            if (bus.I_ADDR_VALID & w_keep_i) begin
                r_overflow[0] <= 1'b1;
            end
            if (bus.D_ADDR_VALID & w_keep_d) begin
                r_overflow[1] <= 1'b1;
            end

            if (w_issue) begin
                r_m_addr  <= w_sel_d ? r_buf_d : r_buf_i;
                r_owner_d <= w_sel_d;
                r_last_d  <= w_sel_d;
                r_state   <= ST_WAIT;
            end else if (w_resp) begin
                r_state <= ST_IDLE;
            end

            // A flushed walk still has its response consumed, just not delivered.
            if (w_resp) begin
                r_drop <= 1'b0;
            end else if (FLUSH & ((r_state == ST_WAIT) | w_issue)) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign w_m_data         = bus.M_DATA;
    assign bus.I_DATA       = w_m_data;
    assign bus.D_DATA       = w_m_data;
    assign bus.I_DATA_VALID = w_deliver & ~r_owner_d;
    assign bus.D_DATA_VALID = w_deliver & r_owner_d;
    assign bus.I_ERR        = w_deliver & ~r_owner_d & bus.M_ERR;
    assign bus.D_ERR        = w_deliver & r_owner_d & bus.M_ERR;
    assign bus.M_ADDR_VALID = r_m_addr_valid;
    assign bus.M_ADDR       = r_m_addr;
    assign OVERFLOW         = r_overflow;
    assign o_state          = r_state;
endmodule

// File: tb/tb_ptw_axim_arbiter.sv
// Bench for ptw_axim_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a per-cycle vector table covers the main flow, hand sequences cover the corner cases.
module tb_ptw_axim_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          FLUSH = 1'b0;
    logic [1:0]    ovf0, ovf1;
    logic [0:0]    st0, st1;

    logic          t_iav = 1'b0, t_dav = 1'b0, t_rdy = 1'b0, t_mdv = 1'b0, t_merr = 1'b0;
    logic [AW-1:0] t_iaddr = '0, t_daddr = '0;
    logic [DW-1:0] t_mdata = '0;

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    ptw_axim_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    ptw_axim_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    assign bus0.I_ADDR_VALID = t_iav;   assign bus1.I_ADDR_VALID = t_iav;
    assign bus0.I_ADDR       = t_iaddr; assign bus1.I_ADDR       = t_iaddr;
    assign bus0.D_ADDR_VALID = t_dav;   assign bus1.D_ADDR_VALID = t_dav;
    assign bus0.D_ADDR       = t_daddr; assign bus1.D_ADDR       = t_daddr;
    assign bus0.M_ADDR_READY = t_rdy;   assign bus1.M_ADDR_READY = t_rdy;
    assign bus0.M_DATA_VALID = t_mdv;   assign bus1.M_DATA_VALID = t_mdv;
    assign bus0.M_DATA       = t_mdata; assign bus1.M_DATA       = t_mdata;
    assign bus0.M_ERR        = t_merr;  assign bus1.M_ERR        = t_merr;

    ptw_axim_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_ENABLE(1)) dut_rr (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .bus(bus0), .OVERFLOW(ovf0), .o_state(st0)
    );
    ptw_axim_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_ENABLE(0)) dut_fp (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .bus(bus1), .OVERFLOW(ovf1), .o_state(st1)
    );

    typedef struct {
        logic          rst;
        logic          iav;
        logic [AW-1:0] iaddr;
        logic          dav;
        logic [AW-1:0] daddr;
        logic          rdy;
        logic          mdv;
        logic [DW-1:0] mdata;
        logic          mav;
        logic [AW-1:0] maddr0;
        logic [AW-1:0] maddr1;
        logic          idv0, ddv0, idv1, ddv1;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(input logic rst, input logic iav, input logic [AW-1:0] iaddr,
                                input logic dav, input logic [AW-1:0] daddr, input logic rdy,
                                input logic mdv, input logic [DW-1:0] mdata, input logic mav,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic i0, input logic d0, input logic i1, input logic d1);
        vec_t v;
        v.rst = rst; v.iav = iav; v.iaddr = iaddr; v.dav = dav; v.daddr = daddr;
        v.rdy = rdy; v.mdv = mdv; v.mdata = mdata; v.mav = mav;
        v.maddr0 = a0; v.maddr1 = a1; v.idv0 = i0; v.ddv0 = d0; v.idv1 = i1; v.ddv1 = d1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_pulses();
        t_iav = 1'b0; t_dav = 1'b0; t_mdv = 1'b0; t_merr = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic do_reset();
        clear_pulses();
        t_rdy = 1'b0;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic chk_both_mav(input string nm, input logic exp);
        chk({nm, "_mav_rr"}, bus0.M_ADDR_VALID, exp);
        chk({nm, "_mav_fp"}, bus1.M_ADDR_VALID, exp);
    endtask

    task automatic chk_both_addr(input string nm, input logic [AW-1:0] exp);
        chk({nm, "_maddr_rr"}, bus0.M_ADDR, exp);
        chk({nm, "_maddr_fp"}, bus1.M_ADDR, exp);
    endtask

    initial begin
        // reset state
        do_reset();
        settle();
        chk_both_mav("rst", 1'b0);
        chk_both_addr("rst", '0);
        chk("rst_ovf_rr", ovf0, 2'b00);
        chk("rst_ovf_fp", ovf1, 2'b00);
        chk("rst_state_rr", st0, 1'b0);
        chk("rst_idv_rr", bus0.I_DATA_VALID, 1'b0);

        // single ITLB request, then RR vs fixed priority on simultaneous requests
        vecs[0]  = mk(0, 1, 64'h8000_1000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h8000_1000, 64'h8000_1000, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1, 1, 64'h2000_00CF, 0, 0, 0, 1, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1, 64'h1000, 1, 64'h2000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h1000, 64'h1000, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 1, 1, 64'h11, 0, 0, 0, 1, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h2000, 64'h2000, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 1, 64'h22, 0, 0, 0, 0, 1, 0, 1);
        vecs[13] = mk(0, 1, 64'h3000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h3000, 64'h3000, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 1, 1, 64'h33, 0, 0, 0, 1, 0, 1, 0);
        vecs[17] = mk(0, 1, 64'h5000, 1, 64'h6000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h6000, 64'h5000, 0, 0, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 1, 1, 64'h44, 0, 0, 0, 0, 1, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 64'h5000, 64'h6000, 0, 0, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 1, 1, 64'h55, 0, 0, 0, 1, 0, 0, 1);
        vecs[24] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 25; k++) begin
            RST = vecs[k].rst;
            t_iav = vecs[k].iav; t_iaddr = vecs[k].iaddr;
            t_dav = vecs[k].dav; t_daddr = vecs[k].daddr;
            t_rdy = vecs[k].rdy; t_mdv = vecs[k].mdv; t_mdata = vecs[k].mdata;
            t_merr = 1'b0;
            settle();
            chk($sformatf("v%0d_mav_rr", k), bus0.M_ADDR_VALID, vecs[k].mav);
            chk($sformatf("v%0d_mav_fp", k), bus1.M_ADDR_VALID, vecs[k].mav);
            if (vecs[k].mav) begin
                chk($sformatf("v%0d_maddr_rr", k), bus0.M_ADDR, vecs[k].maddr0);
                chk($sformatf("v%0d_maddr_fp", k), bus1.M_ADDR, vecs[k].maddr1);
            end
            chk($sformatf("v%0d_idv_rr", k), bus0.I_DATA_VALID, vecs[k].idv0);
            chk($sformatf("v%0d_ddv_rr", k), bus0.D_DATA_VALID, vecs[k].ddv0);
            chk($sformatf("v%0d_idv_fp", k), bus1.I_DATA_VALID, vecs[k].idv1);
            chk($sformatf("v%0d_ddv_fp", k), bus1.D_DATA_VALID, vecs[k].ddv1);
            chk($sformatf("v%0d_ierr_rr", k), bus0.I_ERR, 1'b0);
            if (vecs[k].idv0) chk($sformatf("v%0d_idata_rr", k), bus0.I_DATA, vecs[k].mdata);
            if (vecs[k].ddv0) chk($sformatf("v%0d_ddata_rr", k), bus0.D_DATA, vecs[k].mdata);
            step();
        end
        RST = 1'b0;
        clear_pulses();

        // backpressure: ITLB pending, ready low for 5 cycles
        do_reset();
        t_iav = 1'b1; t_iaddr = 64'h7000; t_rdy = 1'b0;
        step();
        clear_pulses();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk_both_mav($sformatf("bp%0d", k), 1'b0);
            step();
        end
        t_rdy = 1'b1;
        settle();
        chk_both_mav("bp_rise", 1'b0);
        step();
        settle();
        chk_both_mav("bp_issue", 1'b1);
        chk_both_addr("bp_issue", 64'h7000);
        step();
        t_mdv = 1'b1; t_mdata = 64'h77;
        settle();
        chk("bp_idv_rr", bus0.I_DATA_VALID, 1'b1);
        chk("bp_idata_rr", bus0.I_DATA, 64'h77);
        chk("bp_ddv_rr", bus0.D_DATA_VALID, 1'b0);
        step();
        clear_pulses();

        // DTLB request during its own WAIT, and one in its issue cycle: no overflow
        do_reset();
        t_dav = 1'b1; t_daddr = 64'h300; t_rdy = 1'b1;
        step();
        clear_pulses();
        step();
        settle();
        chk_both_mav("dw_issue1", 1'b1);
        chk_both_addr("dw_issue1", 64'h300);
        step();
        t_dav = 1'b1; t_daddr = 64'h400;
        step();
        clear_pulses();
        settle();
        chk("dw_ovf_rr", ovf0, 2'b00);
        t_mdv = 1'b1; t_mdata = 64'h30;
        settle();
        chk("dw_ddv1_rr", bus0.D_DATA_VALID, 1'b1);
        step();
        clear_pulses();
        t_dav = 1'b1; t_daddr = 64'h500;
        step();
        clear_pulses();
        settle();
        chk_both_mav("dw_issue2", 1'b1);
        chk_both_addr("dw_issue2", 64'h400);
        chk("dw_ovf2_rr", ovf0, 2'b00);
        chk("dw_ovf2_fp", ovf1, 2'b00);
        step();
        t_mdv = 1'b1; t_mdata = 64'h40;
        settle();
        chk("dw_ddv2_rr", bus0.D_DATA_VALID, 1'b1);
        step();
        clear_pulses();
        step();
        settle();
        chk_both_mav("dw_issue3", 1'b1);
        chk_both_addr("dw_issue3", 64'h500);
        step();
        t_mdv = 1'b1; t_mdata = 64'h50;
        settle();
        chk("dw_ddv3_fp", bus1.D_DATA_VALID, 1'b1);
        step();
        clear_pulses();

        // overflow: two DTLB requests with ready low; error response
        t_rdy = 1'b0;
        t_dav = 1'b1; t_daddr = 64'h100;
        step();
        t_dav = 1'b1; t_daddr = 64'h200;
        step();
        clear_pulses();
        t_rdy = 1'b1;
        settle();
        chk("ov_set_rr", ovf0, 2'b10);
        chk("ov_set_fp", ovf1, 2'b10);
        chk_both_mav("ov_wait", 1'b0);
        step();
        settle();
        chk_both_mav("ov_issue", 1'b1);
        chk_both_addr("ov_issue", 64'h200);
        step();
        t_mdv = 1'b1; t_merr = 1'b1; t_mdata = 64'hEE;
        settle();
        chk("err_ddv_rr", bus0.D_DATA_VALID, 1'b1);
        chk("err_derr_rr", bus0.D_ERR, 1'b1);
        chk("err_derr_fp", bus1.D_ERR, 1'b1);
        chk("err_ierr_rr", bus0.I_ERR, 1'b0);
        chk("err_idv_rr", bus0.I_DATA_VALID, 1'b0);
        step();
        clear_pulses();
        settle();
        chk("err_ddv_after", bus0.D_DATA_VALID, 1'b0);
        chk("err_derr_after", bus0.D_ERR, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            settle();
            chk_both_mav($sformatf("ov_quiet%0d", k), 1'b0);
            chk($sformatf("ov_sticky%0d", k), ovf0, 2'b10);
        end

        // FLUSH during WAIT with an ITLB request pending
        do_reset();
        t_iav = 1'b1; t_iaddr = 64'hA000; t_rdy = 1'b1;
        step();
        clear_pulses();
        step();
        settle();
        chk_both_mav("fl_issue", 1'b1);
        chk_both_addr("fl_issue", 64'hA000);
        step();
        t_iav = 1'b1; t_iaddr = 64'hB000;
        step();
        clear_pulses();
        FLUSH = 1'b1;
        step();
        clear_pulses();
        t_mdv = 1'b1; t_mdata = 64'hDEAD;
        settle();
        chk("fl_idv_rr", bus0.I_DATA_VALID, 1'b0);
        chk("fl_idv_fp", bus1.I_DATA_VALID, 1'b0);
        chk("fl_ddv_rr", bus0.D_DATA_VALID, 1'b0);
        step();
        clear_pulses();
        settle();
        chk("fl_state_rr", st0, 1'b0);
        chk("fl_state_fp", st1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk_both_mav($sformatf("fl_quiet%0d", k), 1'b0);
            step();
            settle();
        end
        // stray response while idle goes nowhere
        t_mdv = 1'b1; t_mdata = 64'hBAD;
        settle();
        chk("idle_resp_idv", bus0.I_DATA_VALID, 1'b0);
        chk("idle_resp_ddv", bus0.D_DATA_VALID, 1'b0);
        step();
        clear_pulses();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ptw_axim_arbiter.md
Name: ptw_axim_arbiter

Overview:
- Shares the single AXI-master read channel between the ITLB and DTLB page-table walkers.
- Each walker issues one-cycle address pulses and expects one data pulse back per request.
- The arbiter buffers one unissued request per walker, sends one request downstream at a time, and routes the response to the walker that owns it.
- It sits between the two TLBs and the AXI master; a flush input discards stale walks on sfence/satp change.

Parameters:
ADDR_WIDTH, 64, PTE address width
DATA_WIDTH, 64, PTE data width
RR_ENABLE, 1, 1 = round-robin between ports; 0 = fixed priority with ITLB winning

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
FLUSH  in  1  one-cycle pulse: drop buffered requests and any in-flight response
I_ADDR_VALID  in  1  ITLB request pulse
I_ADDR  in  ADDR_WIDTH  ITLB PTE address
I_DATA_VALID  out  1  ITLB response pulse
I_DATA  out  DATA_WIDTH  ITLB PTE data
I_ERR  out  1  ITLB bus-error pulse, coincident with I_DATA_VALID
D_ADDR_VALID  in  1  DTLB request pulse
D_ADDR  in  ADDR_WIDTH  DTLB PTE address
D_DATA_VALID  out  1  DTLB response pulse
D_DATA  out  DATA_WIDTH  DTLB PTE data
D_ERR  out  1  DTLB bus-error pulse
M_ADDR_READY  in  1  AXI master can accept an address
M_ADDR_VALID  out  1  registered one-cycle address pulse to the AXI master
M_ADDR  out  ADDR_WIDTH  address to the AXI master
M_DATA_VALID  in  1  AXI master response pulse
M_DATA  in  DATA_WIDTH  response data
M_ERR  in  1  response error (SLVERR/DECERR)
OVERFLOW  out  2  sticky; bit0 = ITLB, bit1 = DTLB; set when a request overwrites an unissued one

Behaviour:
- Reset values: M_ADDR_VALID=0, M_ADDR=0, OVERFLOW=0, both buffers empty, state IDLE, round-robin pointer favours ITLB, drop flag 0.
- Request capture:
  - X_ADDR_VALID loads buf_X and sets pend_X. This is always accepted, including while port X's earlier request is in flight.
  - If pend_X is already set and not being issued in the same cycle, the new address overwrites the old one and OVERFLOW[X] is set.
  - A request arriving in the same cycle its buffer issues is kept as a new pending entry; this is not an overflow.
- State IDLE:
  - If (pend_I | pend_D) & M_ADDR_READY, select a port.
  - RR_ENABLE=1: if both are pending, take the port not served last. RR_ENABLE=0: ITLB wins.
  - Next cycle: M_ADDR_VALID=1, M_ADDR=buf_sel, owner=sel, pend_sel cleared, last=sel, state WAIT.
  - M_ADDR_VALID is high for exactly one cycle.
- State WAIT:
  - Nothing new is issued (one outstanding transaction).
  - On M_DATA_VALID: combinationally drive owner's X_DATA_VALID=1, X_DATA=M_DATA, X_ERR=M_ERR (zero latency, unless drop is set). Next cycle: state IDLE, drop=0.
  - The earliest next M_ADDR_VALID is 2 cycles after the response.
  - The non-owner's DATA_VALID/ERR stay 0. X_DATA follows M_DATA at all times; it is only meaningful with valid.
- M_DATA_VALID while in IDLE is ignored and routed nowhere.
- FLUSH:
  - Clears pend_I and pend_D.
  - If in WAIT, or issuing this cycle, set drop. The pending response is then consumed with no X_DATA_VALID pulse, and the state returns to IDLE.
  - A request arriving in the same cycle as FLUSH is kept: FLUSH clears first, then capture applies.
  - OVERFLOW is cleared only by RST.
- RST mid-transaction: everything returns to reset values. A subsequent late M_DATA_VALID lands in IDLE and is ignored.
- Widths pass through unchanged; no address arithmetic is performed.

Test Plan:
- Single ITLB request: I_ADDR_VALID with addr 0x8000_1000, M_ADDR_READY=1 → M_ADDR_VALID one cycle later with 0x8000_1000. M_DATA_VALID with data 0x2000_00CF → I_DATA_VALID in the same cycle with 0x2000_00CF; D_DATA_VALID stays 0.
- Simultaneous I and D requests after reset, RR_ENABLE=1:
  - ITLB is issued first; DTLB is issued 2 cycles after the ITLB response.
  - Repeat simultaneous requests → DTLB is issued first this time.
  - With RR_ENABLE=0 → ITLB is always first.
- Backpressure: M_ADDR_READY=0 for 5 cycles with pend_I set → no M_ADDR_VALID. Issue happens on the cycle after ready rises.
- Overflow: two D requests (0x100, then 0x200) while M_ADDR_READY=0 → M_ADDR=0x200 is issued, OVERFLOW=2'b10 and sticky.
  - Also: a D request during its own WAIT → no overflow, and it is issued after the response.
- FLUSH during WAIT with an I request pending → pend_I cleared. The response is dropped (no I_DATA_VALID), state returns to IDLE, and no further M_ADDR_VALID occurs.
- Error path: M_ERR=1 with the response for a DTLB request → D_DATA_VALID=1 and D_ERR=1 for one cycle; I_ERR stays 0.
